// File: rtl/spi_cs_transaction_ctrl_if.sv
// Handshake bundle for the CS transaction sequencer: user-side byte stream plus
// the byte-level SPI_Master TX/RX handshake and the pad chip select.
interface spi_cs_transaction_ctrl_if #(
   parameter int CNT_W = 2
);
   logic [CNT_W-1:0] i_TX_Count;
   logic [7:0]       i_TX_Byte;
   logic             i_TX_DV;
   logic             o_TX_Ready;
   logic [CNT_W-1:0] o_RX_Count;
   logic             o_RX_DV;
   logic [7:0]       o_RX_Byte;
   logic             o_CS_n;
   logic [7:0]       o_M_TX_Byte;
   logic             o_M_TX_DV;
   logic             i_M_TX_Ready;
   logic             i_M_RX_DV;
   logic [7:0]       i_M_RX_Byte;

   modport slave (
      input  i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
      output o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte, o_CS_n, o_M_TX_Byte, o_M_TX_DV
   );

   modport master (
      output i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
      input  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte, o_CS_n, o_M_TX_Byte, o_M_TX_DV
   );
endinterface

// File: rtl/spi_cs_transaction_ctrl.sv
// Chip-select transaction sequencer in front of a byte-level SPI_Master: frames
// multi-byte transfers with programmable CS lead, lag and inactive timing.
module spi_cs_transaction_ctrl #(
   parameter int MAX_BYTES_PER_CS = 2,
   parameter int CS_LEAD_CLKS     = 1,
   parameter int CS_LAG_CLKS      = 1,
   parameter int CS_INACTIVE_CLKS = 1,
   parameter int CNT_W            = $clog2(MAX_BYTES_PER_CS + 1)
) (
   input logic                      i_Clk,
   input logic                      i_Rst_L,
   spi_cs_transaction_ctrl_if.slave bus
);

   // One timer serves the lead, lag and inactive phases, so it is sized for the longest.
   localparam int LL_MAX  = (CS_LEAD_CLKS > CS_LAG_CLKS) ? CS_LEAD_CLKS : CS_LAG_CLKS;
   localparam int TMR_MAX = (LL_MAX > CS_INACTIVE_CLKS) ? LL_MAX : CS_INACTIVE_CLKS;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0] LEAD_LAST  = TMR_W'(CS_LEAD_CLKS - 1);
   localparam logic [TMR_W-1:0] LAG_LAST   = TMR_W'(CS_LAG_CLKS - 1);
   localparam logic [TMR_W-1:0] INACT_LAST = TMR_W'(CS_INACTIVE_CLKS - 1);
   localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
   localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_BYTES_PER_CS);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      ISSUE,
      WAIT_RX,
      NEXT,
      LAG,
      INACTIVE
   } state_t;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] rx_idx_q, rx_idx_d;
   logic             cs_n_q, cs_n_d;
   logic             tx_ready_q, tx_ready_d;
   logic             m_tx_dv_q, m_tx_dv_d;
   logic [7:0]       m_tx_byte_q, m_tx_byte_d;
   logic             rx_dv_q, rx_dv_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic [CNT_W-1:0] rx_count_q, rx_count_d;

   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      remaining_d = remaining_q;
      rx_idx_d    = rx_idx_q;
      cs_n_d      = cs_n_q;
      tx_ready_d  = tx_ready_q;
      m_tx_dv_d   = 1'b0;
      m_tx_byte_d = m_tx_byte_q;
      rx_dv_d     = 1'b0;
      rx_byte_d   = rx_byte_q;
      rx_count_d  = rx_count_q;

      case (state_q)
         IDLE: begin
            if (bus.i_TX_DV && (bus.i_TX_Count != '0)) begin
               m_tx_byte_d = bus.i_TX_Byte;
               remaining_d = (bus.i_TX_Count > MAX_CNT) ? MAX_CNT : bus.i_TX_Count;
               rx_idx_d    = '0;
               tmr_d       = '0;
               cs_n_d      = 1'b0;
               tx_ready_d  = 1'b0;
               state_d     = LEAD;
            end
         end
         LEAD: begin
            if (tmr_q == LEAD_LAST) begin
               tmr_d   = '0;
               state_d = ISSUE;
            end else begin
               tmr_d = tmr_q + TMR_ONE;
            end
         end
         ISSUE: begin
            if (bus.i_M_TX_Ready) begin
               m_tx_dv_d = 1'b1;
               state_d   = WAIT_RX;
            end
         end
         // The received byte is tagged with the index it had before the increment.
         WAIT_RX: begin
            if (bus.i_M_RX_DV) begin
               rx_byte_d   = bus.i_M_RX_Byte;
               rx_count_d  = rx_idx_q;
               rx_dv_d     = 1'b1;
               rx_idx_d    = rx_idx_q + CNT_ONE;
               remaining_d = remaining_q - CNT_ONE;
               if (remaining_q > CNT_ONE) begin
                  tx_ready_d = 1'b1;
                  state_d    = NEXT;
               end else begin
                  tmr_d   = '0;
                  state_d = LAG;
               end
            end
         end
         NEXT: begin
            if (bus.i_TX_DV) begin
               m_tx_byte_d = bus.i_TX_Byte;
               tx_ready_d  = 1'b0;
               state_d     = ISSUE;
            end
         end
         LAG: begin
            if (tmr_q == LAG_LAST) begin
               tmr_d   = '0;
               cs_n_d  = 1'b1;
               state_d = INACTIVE;
            end else begin
               tmr_d = tmr_q + TMR_ONE;
            end
         end
         INACTIVE: begin
            if (tmr_q == INACT_LAST) begin
               tmr_d      = '0;
               tx_ready_d = 1'b1;
               state_d    = IDLE;
            end else begin
               tmr_d = tmr_q + TMR_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         remaining_q <= '0;
         rx_idx_q    <= '0;
         cs_n_q      <= 1'b1;
         tx_ready_q  <= 1'b1;
         m_tx_dv_q   <= 1'b0;
         m_tx_byte_q <= '0;
         rx_dv_q     <= 1'b0;
         rx_byte_q   <= '0;
         rx_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         remaining_q <= remaining_d;
         rx_idx_q    <= rx_idx_d;
         cs_n_q      <= cs_n_d;
         tx_ready_q  <= tx_ready_d;
         m_tx_dv_q   <= m_tx_dv_d;
         m_tx_byte_q <= m_tx_byte_d;
         rx_dv_q     <= rx_dv_d;
         rx_byte_q   <= rx_byte_d;
         rx_count_q  <= rx_count_d;
      end
   end

   assign bus.o_CS_n      = cs_n_q;
   assign bus.o_TX_Ready  = tx_ready_q;
   assign bus.o_M_TX_DV   = m_tx_dv_q;
   assign bus.o_M_TX_Byte = m_tx_byte_q;
   assign bus.o_RX_DV     = rx_dv_q;
   assign bus.o_RX_Byte   = rx_byte_q;
   assign bus.o_RX_Count  = rx_count_q;

endmodule

// File: tb/tb_spi_cs_transaction_ctrl.sv
// Self-checking bench for spi_cs_transaction_ctrl: a mock SPI_Master, a cycle-level
// behavioural model of the CS framing rules, directed scenarios and a random soak.
module tb_spi_cs_transaction_ctrl;

   localparam int MAX_BYTES = 2;
   localparam int LEAD      = 1;
   localparam int LAG       = 1;
   localparam int INACT     = 1;
   localparam int CNT_W     = $clog2(MAX_BYTES + 1);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   spi_cs_transaction_ctrl_if #(.CNT_W(CNT_W)) bus ();

   spi_cs_transaction_ctrl #(
      .MAX_BYTES_PER_CS(MAX_BYTES),
      .CS_LEAD_CLKS    (LEAD),
      .CS_LAG_CLKS     (LAG),
      .CS_INACTIVE_CLKS(INACT),
      .CNT_W           (CNT_W)
   ) dut (
      .i_Clk  (clk),
      .i_Rst_L(rst_n),
      .bus    (bus)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Mock SPI_Master: captures a byte on o_M_TX_DV, answers after mLatency cycles.
   int         mBusy     = 0;
   int         mLatency  = 3;
   logic       forceBusy = 1'b0;
   logic [7:0] mShift    = 8'h00;
   logic [7:0] xorMask   = 8'h00;

   assign bus.i_M_TX_Ready = (mBusy == 0) && !forceBusy;

   always @(negedge clk) begin
      bus.i_M_RX_DV = 1'b0;
      if (!rst_n) begin
         mBusy           = 0;
         bus.i_M_RX_Byte = 8'h00;
      end else if (mBusy > 0) begin
         mBusy--;
         if (mBusy == 0) begin
            bus.i_M_RX_DV   = 1'b1;
            bus.i_M_RX_Byte = mShift ^ xorMask;
         end
      end else if (bus.o_M_TX_DV) begin
         mShift = bus.o_M_TX_Byte;
         mBusy  = mLatency;
      end
   end

   // Behavioural model: phase countdowns and pending-work flags derived from the framing rules.
   logic             expCsN, expTxReady, expMTxDv, expRxDv;
   logic [7:0]       expMTxByte, expRxByte;
   logic [CNT_W-1:0] expRxCount;
   int  leadLeft, lagLeft, inactLeft, bytesLeft, idx;
   bit  wantIssue, awaitRx, awaitNext;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expCsN = 1'b1; expTxReady = 1'b1; expMTxDv = 1'b0; expRxDv = 1'b0;
         expMTxByte = 8'h00; expRxByte = 8'h00; expRxCount = '0;
         leadLeft = 0; lagLeft = 0; inactLeft = 0; bytesLeft = 0; idx = 0;
         wantIssue = 0; awaitRx = 0; awaitNext = 0;
      end else begin
         expMTxDv = 1'b0;
         expRxDv  = 1'b0;
         if (leadLeft > 0) begin
            leadLeft--;
         end else if (wantIssue) begin
            if (bus.i_M_TX_Ready) begin
               expMTxDv  = 1'b1;
               wantIssue = 0;
               awaitRx   = 1;
            end
         end else if (awaitRx) begin
            if (bus.i_M_RX_DV) begin
               expRxDv    = 1'b1;
               expRxByte  = bus.i_M_RX_Byte;
               expRxCount = CNT_W'(idx);
               idx++;
               bytesLeft--;
               awaitRx = 0;
               if (bytesLeft > 0) begin
                  awaitNext  = 1;
                  expTxReady = 1'b1;
               end else begin
                  lagLeft = LAG;
               end
            end
         end else if (awaitNext) begin
            if (bus.i_TX_DV) begin
               expMTxByte = bus.i_TX_Byte;
               expTxReady = 1'b0;
               wantIssue  = 1;
               awaitNext  = 0;
            end
         end else if (lagLeft > 0) begin
            lagLeft--;
            if (lagLeft == 0) begin
               expCsN    = 1'b1;
               inactLeft = INACT;
            end
         end else if (inactLeft > 0) begin
            inactLeft--;
            if (inactLeft == 0) expTxReady = 1'b1;
         end else if (bus.i_TX_DV && (bus.i_TX_Count != '0)) begin
            expMTxByte = bus.i_TX_Byte;
            bytesLeft  = (int'(bus.i_TX_Count) > MAX_BYTES) ? MAX_BYTES : int'(bus.i_TX_Count);
            idx        = 0;
            expCsN     = 1'b0;
            expTxReady = 1'b0;
            leadLeft   = LEAD;
            wantIssue  = 1;
         end
      end
   end

   // Every-cycle comparison of all DUT outputs against the model.
   always @(negedge clk) begin
      checkOutput("o_CS_n",      bus.o_CS_n,      expCsN);
      checkOutput("o_TX_Ready",  bus.o_TX_Ready,  expTxReady);
      checkOutput("o_M_TX_DV",   bus.o_M_TX_DV,   expMTxDv);
      checkOutput("o_M_TX_Byte", bus.o_M_TX_Byte, expMTxByte);
      checkOutput("o_RX_DV",     bus.o_RX_DV,     expRxDv);
      checkOutput("o_RX_Byte",   bus.o_RX_Byte,   expRxByte);
      checkOutput("o_RX_Count",  bus.o_RX_Count,  expRxCount);
   end

   // Event logs used by the directed scenarios.
   logic [7:0] txLog[$];
   int         txCyc[$];
   logic [7:0] rxByteLog[$];
   int         rxIdxLog[$];
   int         rxCyc[$];
   int         csFalls = 0, csRises = 0, csFallCyc = 0, csRiseCyc = 0, readyRiseCyc = 0;
   logic       prevCsN = 1'b1, prevRdy = 1'b1;

   always @(negedge clk) begin
      if (bus.o_M_TX_DV) begin
         txLog.push_back(bus.o_M_TX_Byte);
         txCyc.push_back(cyc);
      end
      if (bus.o_RX_DV) begin
         rxByteLog.push_back(bus.o_RX_Byte);
         rxIdxLog.push_back(int'(bus.o_RX_Count));
         rxCyc.push_back(cyc);
      end
      if (prevCsN && !bus.o_CS_n) begin csFalls++; csFallCyc = cyc; end
      if (!prevCsN && bus.o_CS_n) begin csRises++; csRiseCyc = cyc; end
      if (!prevRdy && bus.o_TX_Ready) readyRiseCyc = cyc;
      prevCsN = bus.o_CS_n;
      prevRdy = bus.o_TX_Ready;
   end

   int dvCyc = 0;

   task automatic clearLogs();
      txLog.delete(); txCyc.delete();
      rxByteLog.delete(); rxIdxLog.delete(); rxCyc.delete();
      csFalls = 0; csRises = 0;
   endtask

   task automatic applyStimulus(input int count, input logic [7:0] data);
      @(negedge clk);
      bus.i_TX_Count = CNT_W'(count);
      bus.i_TX_Byte  = data;
      bus.i_TX_DV    = 1'b1;
      dvCyc          = cyc;
      @(negedge clk);
      bus.i_TX_DV = 1'b0;
   endtask

   task automatic waitIdle(input string name);
      bit done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (bus.o_TX_Ready && bus.o_CS_n) done = 1;
      end
      checkOutput(name, done, 1'b1);
      #1;
   endtask

   task automatic supplyNext(input string name, input logic [7:0] data, input int gap);
      bit found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         if (bus.o_TX_Ready && !bus.o_CS_n) found = 1;
      end
      checkOutput(name, found, 1'b1);
      repeat (gap) @(negedge clk);
      bus.i_TX_Byte = data;
      bus.i_TX_DV   = 1'b1;
      @(negedge clk);
      bus.i_TX_DV = 1'b0;
   endtask

   task automatic waitTxPulse(input string name);
      bit seen = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (bus.o_M_TX_DV) seen = 1;
      end
      checkOutput(name, seen, 1'b1);
   endtask

   initial begin
      bus.i_TX_Count = '0;
      bus.i_TX_Byte  = 8'h00;
      bus.i_TX_DV    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset cs_n",     bus.o_CS_n,      1'b1);
      checkOutput("reset tx_ready", bus.o_TX_Ready,  1'b1);
      checkOutput("reset m_tx_byte", bus.o_M_TX_Byte, 8'h00);
      checkOutput("reset rx_count", bus.o_RX_Count,  '0);

      $display("[TB] single byte 0xC1");
      clearLogs();
      applyStimulus(1, 8'hC1);
      waitIdle("single idle");
      checkOutput("single cs fall delay", csFallCyc - dvCyc, 1);
      checkOutput("single tx pulses", txLog.size(), 1);
      checkOutput("single tx byte", txLog[0], 8'hC1);
      checkOutput("single tx after cs", txCyc[0] - csFallCyc, 2);
      checkOutput("single rx count", rxByteLog.size(), 1);
      checkOutput("single rx byte", rxByteLog[0], 8'hC1);
      checkOutput("single rx index", rxIdxLog[0], 0);
      checkOutput("single cs rise delay", csRiseCyc - rxCyc[0], 1);
      checkOutput("single ready delay", readyRiseCyc - csRiseCyc, 1);

      $display("[TB] two bytes 0xBE 0xEF");
      clearLogs();
      applyStimulus(2, 8'hBE);
      supplyNext("two next reached", 8'hEF, 5);
      waitIdle("two idle");
      checkOutput("two cs falls", csFalls, 1);
      checkOutput("two cs rises", csRises, 1);
      checkOutput("two tx pulses", txLog.size(), 2);
      checkOutput("two rx 0 byte", rxByteLog[0], 8'hBE);
      checkOutput("two rx 0 index", rxIdxLog[0], 0);
      checkOutput("two rx 1 byte", rxByteLog[1], 8'hEF);
      checkOutput("two rx 1 index", rxIdxLog[1], 1);

      $display("[TB] zero and clamped counts");
      clearLogs();
      applyStimulus(0, 8'h12);
      repeat (10) @(negedge clk);
      #1;
      checkOutput("zero cs falls", csFalls, 0);
      checkOutput("zero tx pulses", txLog.size(), 0);
      applyStimulus(3, 8'h21);
      supplyNext("clamp next reached", 8'h43, 0);
      waitIdle("clamp idle");
      repeat (6) @(negedge clk);
      #1;
      checkOutput("clamp tx pulses", txLog.size(), 2);
      checkOutput("clamp rx count", rxByteLog.size(), 2);
      checkOutput("clamp cs rises", csRises, 1);

      $display("[TB] master busy hold");
      clearLogs();
      forceBusy = 1'b1;
      applyStimulus(1, 8'h7E);
      repeat (4) @(negedge clk);
      forceBusy = 1'b0;
      dvCyc     = cyc;
      waitIdle("busy idle");
      checkOutput("busy tx pulses", txLog.size(), 1);
      checkOutput("busy pulse timing", txCyc[0] - dvCyc, 1);

      $display("[TB] ignored strobes in WAIT_RX and INACTIVE");
      clearLogs();
      applyStimulus(1, 8'h3C);
      waitTxPulse("illegal tx seen");
      @(negedge clk);
      bus.i_TX_Count = CNT_W'(1);
      bus.i_TX_Byte  = 8'h55;
      bus.i_TX_DV    = 1'b1;
      @(negedge clk);
      bus.i_TX_DV = 1'b0;
      for (int c = 0; c < 50 && !bus.o_CS_n; c++) @(negedge clk);
      checkOutput("illegal in inactive", {bus.o_CS_n, bus.o_TX_Ready}, 2'b10);
      bus.i_TX_DV = 1'b1;
      @(negedge clk);
      bus.i_TX_DV = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      checkOutput("illegal tx pulses", txLog.size(), 1);
      checkOutput("illegal cs falls", csFalls, 1);
      checkOutput("illegal rx byte", rxByteLog[0], 8'h3C);

      $display("[TB] reset during WAIT_RX");
      clearLogs();
      applyStimulus(1, 8'h99);
      waitTxPulse("reset tx seen");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async cs_n", bus.o_CS_n, 1'b1);
      checkOutput("async tx_ready", bus.o_TX_Ready, 1'b1);
      checkOutput("async rx_dv", bus.o_RX_DV, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      checkOutput("reset no rx", rxByteLog.size(), 0);
      clearLogs();
      applyStimulus(1, 8'hAA);
      waitIdle("post reset idle");
      checkOutput("post reset tx", txLog.size(), 1);
      checkOutput("post reset rx byte", rxByteLog[0], 8'hAA);
      checkOutput("post reset rx index", rxIdxLog[0], 0);

      $display("[TB] random soak");
      for (int t = 0; t < 40; t++) begin
         int gap;
         bit done;
         mLatency = $urandom_range(1, 4);
         xorMask  = 8'($urandom_range(0, 255));
         applyStimulus($urandom_range(0, 3), 8'($urandom_range(0, 255)));
         gap  = $urandom_range(0, 4);
         done = 0;
         for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            bus.i_TX_DV = 1'b0;
            forceBusy   = ($urandom_range(0, 3) == 0);
            if (bus.o_TX_Ready && bus.o_CS_n) begin
               done = 1;
            end else if (bus.o_TX_Ready) begin
               if (gap == 0) begin
                  bus.i_TX_Byte = 8'($urandom_range(0, 255));
                  bus.i_TX_DV   = 1'b1;
                  gap           = $urandom_range(0, 4);
               end else begin
                  gap--;
               end
            end else if ($urandom_range(0, 7) == 0) begin
               bus.i_TX_Byte  = 8'($urandom_range(0, 255));
               bus.i_TX_Count = CNT_W'($urandom_range(0, 3));
               bus.i_TX_DV    = 1'b1;
            end
         end
         forceBusy = 1'b0;
         checkOutput("random idle", done, 1'b1);
      end

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_cs_transaction_ctrl.md
Name: spi_cs_transaction_ctrl

Overview:
Chip-select transaction sequencer that sits directly upstream of the byte-level SPI_Master. It accepts multi-byte transactions from the user side and drives an active-low chip select with programmable lead, lag and inactive timing. It feeds bytes one at a time through the master's TX_DV/TX_Ready handshake and returns each received byte tagged with its index. The SPI_Master's o_SPI_Clk, o_SPI_MOSI and i_SPI_MISO pins are not touched by this block; only o_CS_n goes to the pad.

Parameters:
MAX_BYTES_PER_CS, 2, maximum bytes per CS assertion; i_TX_Count is clamped to this value.
CS_LEAD_CLKS, 1, i_Clk cycles with CS low before the first o_M_TX_DV (minimum 1).
CS_LAG_CLKS, 1, i_Clk cycles CS stays low after the last i_M_RX_DV (minimum 1).
CS_INACTIVE_CLKS, 1, i_Clk cycles CS stays high before the next transaction can start (minimum 1).
CNT_W, $clog2(MAX_BYTES_PER_CS+1), width of the count and index fields.

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_TX_Count  in  CNT_W  bytes in the transaction; sampled only with the first i_TX_DV
i_TX_Byte  in  8  TX byte from the user
i_TX_DV  in  1  one-cycle strobe; valid only while o_TX_Ready=1
o_TX_Ready  out  1  block can accept the next byte
o_RX_Count  out  CNT_W  0-based index of o_RX_Byte within the transaction
o_RX_DV  out  1  one-cycle RX strobe
o_RX_Byte  out  8  received byte
o_CS_n  out  1  active-low chip select to the pad
o_M_TX_Byte  out  8  to SPI_Master i_TX_Byte
o_M_TX_DV  out  1  to SPI_Master i_TX_DV; one-cycle pulse
i_M_TX_Ready  in  1  from SPI_Master o_TX_Ready
i_M_RX_DV  in  1  from SPI_Master o_RX_DV
i_M_RX_Byte  in  8  from SPI_Master o_RX_Byte

Behaviour:
- Reset (asynchronous, immediate):
  - o_CS_n=1; o_TX_Ready=1; o_M_TX_DV=0; o_RX_DV=0.
  - o_RX_Byte, o_RX_Count and o_M_TX_Byte clear to 0.
  - State returns to IDLE and all counters clear.
  - Reset mid-transaction drops CS without completing the byte; no RX strobe is emitted.
- States: IDLE, LEAD, ISSUE, WAIT_RX, NEXT, LAG, INACTIVE.
- IDLE:
  - o_TX_Ready=1.
  - i_TX_DV with i_TX_Count=0 is ignored; state stays IDLE.
  - Otherwise latch the byte and remaining=min(i_TX_Count, MAX_BYTES_PER_CS), clear the RX index, then go to LEAD.
  - o_CS_n=0 and o_TX_Ready=0 from the next edge.
- LEAD: counts CS_LEAD_CLKS cycles, then goes to ISSUE.
- ISSUE:
  - When i_M_TX_Ready=1, pulse o_M_TX_DV for exactly 1 cycle with o_M_TX_Byte=latched byte, then go to WAIT_RX.
  - If i_M_TX_Ready=0, hold in ISSUE.
- WAIT_RX:
  - On i_M_RX_DV: register o_RX_Byte=i_M_RX_Byte and o_RX_Count=RX index, and pulse o_RX_DV on the following cycle (1-cycle latency).
  - Increment the index and decrement remaining.
  - Go to NEXT if remaining>0, else to LAG.
  - i_M_RX_DV in any other state is ignored.
- NEXT:
  - o_TX_Ready=1 and CS is held low indefinitely.
  - i_TX_DV latches the byte, drives o_TX_Ready=0 next cycle, and goes to ISSUE. No lead delay applies between bytes.
- LAG: CS stays low for CS_LAG_CLKS cycles, then o_CS_n=1 and go to INACTIVE.
- INACTIVE: CS high and o_TX_Ready=0 for CS_INACTIVE_CLKS cycles, then go to IDLE.
- Simultaneous events: i_TX_DV while o_TX_Ready=0 is dropped silently. i_M_RX_DV and an o_RX_DV of a previous byte cannot overlap, because each byte completes serially.
- o_M_TX_DV is never asserted while o_CS_n=1.

Test Plan:
- Single byte, all timing parameters at 1, loopback master model: i_TX_Count=1, i_TX_Byte=0xC1.
  - Required: CS falls 1 cycle after DV and o_M_TX_DV pulses once with 0xC1.
  - Required: o_RX_DV with o_RX_Byte=0xC1, o_RX_Count=0.
  - Required: CS rises 1 cycle after RX, and o_TX_Ready returns 1 cycle after CS rises.
- Two bytes, 0xBE then 0xEF, second byte supplied 5 cycles after NEXT is entered.
  - Required: CS is continuously low throughout.
  - Required: RX 0xBE at index 0 and RX 0xEF at index 1.
  - Required: exactly 2 o_M_TX_DV pulses.
- Edge counts: i_TX_Count=0 -> CS never falls and no o_M_TX_DV pulse; i_TX_Count=3 with MAX_BYTES_PER_CS=2 -> exactly 2 bytes are transferred before CS rises.
- Master busy: hold i_M_TX_Ready=0 for 4 cycles after LEAD.
  - Required: no o_M_TX_DV during the hold.
  - Required: the pulse occurs on the first cycle Ready is high.
- Illegal input: i_TX_DV=1 with 0x55 during WAIT_RX and during INACTIVE -> ignored, and no extra TX byte or CS toggle.
- Reset mid-transaction: i_Rst_L=0 during WAIT_RX of byte 0.
  - Required: o_CS_n=1 asynchronously, no o_RX_DV, o_TX_Ready=1.
  - Required: a subsequent 1-byte transaction of 0xAA completes normally.
